// File: rtl/fetch_decode.sv
// Multi-cycle RISC-V (subset) fetch/decode controller: owns the PC, fetches over req/ack, drives the datapath control bus.
// Optional feature macro FD_INSTRET_EN: when defined, instret counts retired instructions; otherwise instret is tied to 0.
module fetch_decode #(
    parameter int NBITS      = 8,
    parameter int NREGS      = 32,
    parameter int WIDTH_ALUF = 4,
    localparam int RW        = $clog2(NREGS)
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [NBITS-1:0]      imem_addr,
    output logic                  imem_req,
    input  logic                  imem_ack,
    input  logic [31:0]           imem_rdata,
    output logic [RW-1:0]         RS1,
    output logic [RW-1:0]         RS2,
    output logic [RW-1:0]         RD,
    output logic [NBITS-1:0]      IMM,
    output logic [WIDTH_ALUF-1:0] ALUControl,
    output logic                  ALUSrc,
    output logic                  MemtoReg,
    output logic                  RegWrite,
    output logic                  link,
    output logic [NBITS-1:0]      pclink,
    input  logic [NBITS-1:0]      PCReg,
    input  logic                  Zero,
    input  logic                  Neg,
    input  logic                  Carry,
    output logic                  halted,
    output logic                  illegal,
    output logic [NBITS-1:0]      instret,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

    // imem handshake: imem_req is high throughout FETCH with imem_addr held at the PC;
    // the word on imem_rdata is taken in the first FETCH cycle where imem_ack is high.
    state_t             state_q;
    logic [NBITS-1:0]   pc_q;
    logic [31:0]        ir_q;
    logic               illegal_q;
    logic               req_q;
    logic               halted_q;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_b, imm_j, imm_sel;
    logic        is_addi, is_add, is_sub, is_jal, is_jalr, is_beq, is_bne, is_branch, is_ebreak;
    logic        legal, writes_rd, branch_taken, in_exec;
    logic [NBITS-1:0] pc_plus4, jalr_sum, pc_d;
    logic        unused_ok;

    assign opcode = ir_q[6:0];
    assign funct3 = ir_q[14:12];
    assign funct7 = ir_q[31:25];

    assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    assign is_addi   = (opcode == 7'b0010011) && (funct3 == 3'b000);
    assign is_add    = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
    assign is_sub    = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0100000);
    assign is_jal    = (opcode == 7'b1101111);
    assign is_jalr   = (opcode == 7'b1100111) && (funct3 == 3'b000);
    assign is_beq    = (opcode == 7'b1100011) && (funct3 == 3'b000);
    assign is_bne    = (opcode == 7'b1100011) && (funct3 == 3'b001);
    assign is_branch = is_beq || is_bne;
    assign is_ebreak = (ir_q == 32'h0010_0073);

    assign legal        = is_addi || is_add || is_sub || is_jal || is_jalr || is_branch || is_ebreak;
    assign writes_rd    = is_addi || is_add || is_sub || is_jal || is_jalr;
    assign branch_taken = (is_beq && Zero) || (is_bne && !Zero);
    assign in_exec      = (state_q == S_EXEC);

    assign pc_plus4 = pc_q + NBITS'(4);
    assign jalr_sum = PCReg + imm_i[NBITS-1:0];

    always_comb begin
        pc_d = pc_plus4;
        if (is_jal)
            pc_d = pc_q + imm_j[NBITS-1:0];
        else if (is_jalr)
            pc_d = {jalr_sum[NBITS-1:1], 1'b0};
        else if (branch_taken)
            pc_d = pc_q + imm_b[NBITS-1:0];
    end

    always_comb begin
        imm_sel = imm_i;
        if (is_jal)
            imm_sel = imm_j;
        else if (is_branch)
            imm_sel = imm_b;
    end

    // Control outputs are qualified by EXEC so the datapath sees a quiet bus while fetching.
    assign RS1        = ir_q[15 +: RW];
    assign RS2        = ir_q[20 +: RW];
    assign RD         = ir_q[7 +: RW];
    assign IMM        = imm_sel[NBITS-1:0];
    assign ALUSrc     = in_exec && is_addi;
    assign ALUControl = (in_exec && (is_sub || is_branch)) ? WIDTH_ALUF'(1) : '0;
    assign MemtoReg   = 1'b0;
    assign RegWrite   = in_exec && writes_rd && (RD != '0);
    assign link       = in_exec && (is_jal || is_jalr);
    assign pclink     = pc_plus4;

    assign imem_addr   = pc_q;
    assign imem_req    = req_q;
    assign halted      = halted_q;
    assign illegal     = illegal_q;
    assign dbg_state_o = state_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            ir_q      <= 32'h0000_0013;
            illegal_q <= 1'b0;
            req_q     <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_FETCH;
                    req_q   <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        ir_q    <= imem_rdata;
                        state_q <= S_EXEC;
                        req_q   <= 1'b0;
                    end
                end
                S_EXEC: begin
                    if (!legal || is_ebreak) begin
                        illegal_q <= illegal_q || !legal;
                        halted_q  <= 1'b1;
                        state_q   <= S_HALT;
                    end else begin
                        pc_q    <= pc_d;
                        req_q   <= 1'b1;
                        state_q <= S_FETCH;
                    end
                end
                S_HALT: state_q <= S_HALT;
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef FD_INSTRET_EN
    logic [NBITS-1:0] instret_q;

    always_ff @(posedge clock) begin
        if (reset)
            instret_q <= '0;
        else if (in_exec && legal && !is_ebreak)
            instret_q <= instret_q + NBITS'(1);
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

    // Neg/Carry are not needed by any supported instruction; immediates are only partly consumed.
    assign unused_ok = ^{Neg, Carry, imm_i, imm_b, imm_j};

endmodule

// File: tb/tb_fetch_decode.sv
// Bench for fetch_decode: directed sequences plus randomized instruction stream checked against an ISA-level model.
// Honours FD_INSTRET_EN the same way as the design.
module tb_fetch_decode;
    localparam int NBITS      = 8;
    localparam int NREGS      = 32;
    localparam int WIDTH_ALUF = 4;
    localparam int RW         = $clog2(NREGS);
    localparam int MASK       = (1 << NBITS) - 1;

    logic                  clock;
    logic                  reset;
    logic [NBITS-1:0]      imem_addr;
    logic                  imem_req;
    logic                  imem_ack;
    logic [31:0]           imem_rdata;
    logic [RW-1:0]         RS1, RS2, RD;
    logic [NBITS-1:0]      IMM;
    logic [WIDTH_ALUF-1:0] ALUControl;
    logic                  ALUSrc, MemtoReg, RegWrite, link;
    logic [NBITS-1:0]      pclink;
    logic [NBITS-1:0]      PCReg;
    logic                  Zero, Neg, Carry;
    logic                  halted, illegal;
    logic [NBITS-1:0]      instret;
    logic [1:0]            dbg_state;

    fetch_decode #(.NBITS(NBITS), .NREGS(NREGS), .WIDTH_ALUF(WIDTH_ALUF)) dut (
        .clock(clock), .reset(reset),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .RS1(RS1), .RS2(RS2), .RD(RD), .IMM(IMM), .ALUControl(ALUControl), .ALUSrc(ALUSrc),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .link(link), .pclink(pclink),
        .PCReg(PCReg), .Zero(Zero), .Neg(Neg), .Carry(Carry),
        .halted(halted), .illegal(illegal), .instret(instret), .dbg_state_o(dbg_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // scoreboard: expected fetch addresses, retired count
    int n_checks;
    int n_bad;
    int retired;
    int last_pc;
    logic [NBITS-1:0] exp_q[$];

    typedef struct {
        bit legal, halt, rw, lnk, src;
        int aluc, rs1, rs2, rd, imm, npc;
        bit c_rs1, c_rs2, c_rd, c_imm;
    } exp_t;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_instret();
`ifdef FD_INSTRET_EN
        return retired & MASK;
`else
        return 0;
`endif
    endfunction

    // ISA-level reference: decode fields with integer arithmetic, PC math mod 2^NBITS.
    function automatic exp_t ref_model(input logic [31:0] ins, input int pc, input bit zero, input int pcreg);
        exp_t e;
        int s, op, f3, f7, rd, rs1, rs2, iimm, bimm, jimm;
        bit taken;
        e = '{default: 0};
        s    = ins;
        op   = s & 127;
        f3   = (s >> 12) & 7;
        f7   = (s >> 25) & 127;
        rd   = ((s >> 7) & 31) % NREGS;
        rs1  = ((s >> 15) & 31) % NREGS;
        rs2  = ((s >> 20) & 31) % NREGS;
        iimm = s >>> 20;
        bimm = (s < 0 ? -4096 : 0) + ((s >> 7) & 1) * 2048 + ((s >> 25) & 63) * 32 + ((s >> 8) & 15) * 2;
        jimm = (s < 0 ? -(1 << 20) : 0) + ((s >> 12) & 255) * 4096 + ((s >> 20) & 1) * 2048
             + ((s >> 21) & 1023) * 2;
        e.legal = 1;
        e.npc   = (pc + 4) & MASK;
        e.rs1   = rs1;
        e.rs2   = rs2;
        e.rd    = rd;
        e.imm   = iimm & MASK;
        if (ins == 32'h0010_0073) begin
            e.halt = 1;
        end else if (op == 'h13 && f3 == 0) begin
            e.src = 1; e.rw = (rd != 0); e.c_rs1 = 1; e.c_rd = 1; e.c_imm = 1;
        end else if (op == 'h33 && f3 == 0 && (f7 == 0 || f7 == 32)) begin
            e.aluc = (f7 == 32) ? 1 : 0; e.rw = (rd != 0); e.c_rs1 = 1; e.c_rs2 = 1; e.c_rd = 1;
        end else if (op == 'h6f) begin
            e.lnk = 1; e.rw = (rd != 0); e.c_rd = 1;
            e.npc = (pc + jimm) & MASK;
        end else if (op == 'h67 && f3 == 0) begin
            e.lnk = 1; e.rw = (rd != 0); e.c_rs1 = 1; e.c_rd = 1; e.c_imm = 1;
            e.npc = ((pcreg + iimm) & MASK) & ~1;
        end else if (op == 'h63 && f3 < 2) begin
            e.aluc = 1; e.c_rs1 = 1; e.c_rs2 = 1;
            taken = (f3 == 0) ? zero : !zero;
            if (taken) e.npc = (pc + bimm) & MASK;
        end else begin
            e.legal = 0; e.halt = 1;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [4:0]  rd, rs1, rs2;
        r   = $urandom;
        rd  = 5'($urandom);
        rs1 = 5'($urandom);
        rs2 = 5'($urandom);
        case ($urandom_range(0, 5))
            0: return {r[31:20], rs1, 3'b000, rd, 7'h13};
            1: return {(r[0] ? 7'h20 : 7'h00), rs2, rs1, 3'b000, rd, 7'h33};
            2: return {r[31:12], rd, 7'h6f};
            3: return {r[31:20], rs1, 3'b000, rd, 7'h67};
            4: return {r[31:25], rs2, rs1, 2'b00, r[1], r[11:7], 7'h63};
            default: return {r[31:20], 5'd0, 3'b000, rd, 7'h13};
        endcase
    endfunction

    // driver tasks
    task automatic check_quiet(input string tag);
        check_eq({tag, "_regwrite"}, RegWrite, 0);
        check_eq({tag, "_link"}, link, 0);
        check_eq({tag, "_alusrc"}, ALUSrc, 0);
        check_eq({tag, "_aluctl"}, ALUControl, 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset    = 1'b1;
        imem_ack = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        check_eq("idle_req", imem_req, 0);
        check_eq("idle_halted", halted, 0);
        check_eq("idle_illegal", illegal, 0);
        check_eq("idle_instret", instret, 0);
        check_quiet("idle");
        exp_q.delete();
        exp_q.push_back('0);
        retired = 0;
    endtask

    task automatic run_instr(input logic [31:0] ins, input int delay, input bit zero, input int pcreg);
        exp_t e;
        int pc;
        pc = (exp_q.size() > 0) ? int'(exp_q.pop_front()) : 0;
        last_pc = pc;
        for (int i = 0; i <= delay; i++) begin
            @(negedge clock);
            check_eq("fetch_req", imem_req, 1);
            check_eq("fetch_addr", imem_addr, pc);
            check_eq("fetch_halted", halted, 0);
            if (i == 0) check_eq("instret", instret, exp_instret());
            check_quiet("fetch");
            imem_ack   = (i == delay);
            imem_rdata = (i == delay) ? ins : $urandom;
            Zero       = 1'($urandom);
            PCReg      = NBITS'($urandom);
        end
        @(negedge clock);
        imem_ack   = 1'($urandom);
        imem_rdata = $urandom;
        Zero       = zero;
        PCReg      = NBITS'(pcreg);
        #1;
        e = ref_model(ins, pc, zero, pcreg & MASK);
        check_eq("exec_regwrite", RegWrite, e.rw);
        check_eq("exec_link", link, e.lnk);
        check_eq("exec_alusrc", ALUSrc, e.src);
        check_eq("exec_aluctl", ALUControl, e.aluc);
        check_eq("exec_memtoreg", MemtoReg, 0);
        check_eq("exec_pclink", pclink, (pc + 4) & MASK);
        check_eq("exec_halted", halted, 0);
        if (e.c_rs1) check_eq("exec_rs1", RS1, e.rs1);
        if (e.c_rs2) check_eq("exec_rs2", RS2, e.rs2);
        if (e.c_rd)  check_eq("exec_rd", RD, e.rd);
        if (e.c_imm) check_eq("exec_imm", IMM, e.imm);
        if (e.legal && !e.halt) begin
            exp_q.push_back(NBITS'(e.npc));
            retired++;
        end
    endtask

    task automatic halt_check(input bit exp_ill, input int cycles, input int pc);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            imem_ack   = 1'($urandom);
            imem_rdata = $urandom;
            #1;
            check_eq("halt_halted", halted, 1);
            check_eq("halt_req", imem_req, 0);
            check_eq("halt_illegal", illegal, exp_ill);
            check_eq("halt_instret", instret, exp_instret());
            if (exp_ill) check_eq("halt_pc", imem_addr, pc);
            check_quiet("halt");
        end
        imem_ack = 1'b0;
    endtask

    task automatic reset_mid_fetch();
        int pc;
        pc = (exp_q.size() > 0) ? int'(exp_q.pop_front()) : 0;
        @(negedge clock);
        check_eq("midrst_req", imem_req, 1);
        check_eq("midrst_addr", imem_addr, pc);
        check_eq("midrst_instret", instret, exp_instret());
        reset      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'h0050_0093;
        @(negedge clock);
        reset    = 1'b0;
        imem_ack = 1'b0;
        check_eq("midrst_idle_req", imem_req, 0);
        check_eq("midrst_instret0", instret, 0);
        check_eq("midrst_illegal", illegal, 0);
        check_quiet("midrst");
        exp_q.delete();
        exp_q.push_back('0);
        retired = 0;
    endtask

    initial begin
        reset      = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        PCReg      = '0;
        Zero       = 1'b0;
        Neg        = 1'b0;
        Carry      = 1'b0;
        n_checks   = 0;
        n_bad      = 0;
        retired    = 0;
        last_pc    = 0;

        do_reset();
        run_instr(32'h0050_0093, 0, 1'b0, 0);   // addi x1,x0,5 at 0
        run_instr(32'h0080_00EF, 3, 1'b0, 0);   // jal x1,+8 at 4, ack after 3 waits
        run_instr(32'hFE20_8CE3, 0, 1'b1, 0);   // beq taken at 12 -> 4
        run_instr(32'h0080_006F, 1, 1'b0, 0);   // jal x0,+8 at 4 -> 12
        run_instr(32'hFE20_8CE3, 2, 1'b0, 0);   // beq not taken at 12 -> 16
        run_instr(32'h0000_0013, 0, 1'b0, 0);   // nop: no register write

        for (int n = 0; n < 150; n++)
            run_instr(rand_instr(), int'($urandom_range(0, 3)), 1'($urandom),
                      int'($urandom_range(0, MASK)));

        run_instr(32'hFFFF_FFFF, 1, 1'b0, 0);
        halt_check(1'b1, 12, last_pc);

        do_reset();
        run_instr(32'h0010_0073, 0, 1'b0, 0);
        halt_check(1'b0, 12, 0);

        do_reset();
        for (int n = 0; n < 3; n++)
            run_instr({12'(n + 1), 5'd0, 3'b000, 5'd2, 7'h13}, int'($urandom_range(0, 2)), 1'b0, 0);
        reset_mid_fetch();
        run_instr(32'h0050_0093, 1, 1'b0, 0);
        run_instr(32'h0000_0013, 0, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
